// File: rtl/frame_buffer_ctrl.sv
// Framebuffer controller: clear engine, draw-write port and registered VGA read port
// over one RAM holding NUM_BUF frames, with front/back swap gated to frame_start.
module frame_buffer_ctrl #(
  parameter int               H_RES     = 640,
  parameter int               V_RES     = 480,
  parameter int               COORD_W   = 10,
  parameter int               PIX_W     = 1,
  parameter int               NUM_BUF   = 2,
  parameter logic [PIX_W-1:0] CLEAR_VAL = '0
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               clear_start,
  output logic               clear_done,
  input  logic               draw_we,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic [PIX_W-1:0]   draw_data,
  output logic               draw_ready,
  input  logic [COORD_W-1:0] ReadX,
  input  logic [COORD_W-1:0] ReadY,
  output logic [PIX_W-1:0]   read_data,
  input  logic               swap_req,
  input  logic               frame_start,
  output logic               swap_done,
  output logic               front_sel,
  output logic               busy
);

  localparam int FRAME  = H_RES * V_RES;
  localparam int DEPTH  = NUM_BUF * FRAME;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (FRAME > 1) ? $clog2(FRAME) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              swap_pend, pend_n;
  logic              front_n, clear_done_n, swap_done_n;
  logic              back_sel, draw_ok, read_ok;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [PIX_W-1:0]  wr_data;
  logic [PIX_W-1:0]  mem [DEPTH];

  function automatic logic [ADDR_W-1:0] pix_addr(input logic sel, input int offset);
    return ADDR_W'(int'(sel) * FRAME + offset);
  endfunction

  assign back_sel   = (NUM_BUF == 2) ? ~front_sel : 1'b0;
  assign draw_ok    = (int'(DrawX) < H_RES) && (int'(DrawY) < V_RES);
  assign read_ok    = (int'(ReadX) < H_RES) && (int'(ReadY) < V_RES);
  assign rd_addr    = pix_addr(front_sel, int'(ReadY) * H_RES + int'(ReadX));
  assign busy       = (state != IDLE);
  assign draw_ready = (state == IDLE);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_n      = state;
    cnt_n        = cnt;
    pend_n       = swap_pend;
    front_n      = front_sel;
    clear_done_n = 1'b0;
    swap_done_n  = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = pix_addr(back_sel, int'(DrawY) * H_RES + int'(DrawX));
    wr_data      = draw_data;
    case (state)
      IDLE: begin
        wr_en = draw_we && draw_ok;
        if (clear_start) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end else if (swap_req || swap_pend) begin
          state_n = SWAP_WAIT;
        end
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = pix_addr(back_sel, int'(cnt));
        wr_data = CLEAR_VAL;
        if (swap_req) pend_n = 1'b1;
        if (cnt == CNT_W'(FRAME - 1)) begin
          state_n      = IDLE;
          cnt_n        = '0;
          clear_done_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SWAP_WAIT: begin
        // A single buffer still completes the handshake; it just never flips.
        if (frame_start) begin
          front_n     = (NUM_BUF == 2) ? ~front_sel : 1'b0;
          swap_done_n = 1'b1;
          pend_n      = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      swap_pend  <= 1'b0;
      front_sel  <= 1'b0;
      clear_done <= 1'b0;
      swap_done  <= 1'b0;
      read_data  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state      <= state_n;
      cnt        <= cnt_n;
      swap_pend  <= pend_n;
      front_sel  <= front_n;
      clear_done <= clear_done_n;
      swap_done  <= swap_done_n;
      read_data  <= read_ok ? mem[rd_addr] : CLEAR_VAL;
    end
  end

  // NOTE: the pixel array has no reset so it can map onto block RAM; the clear engine initialises it.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Bench for frame_buffer_ctrl: a double- and a single-buffer instance share stimulus and are
// compared every cycle against a pixel-array model, plus directed literal scenarios.
module tb_frame_buffer_ctrl;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int FRAME = H * V;
  localparam int CW    = 10;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          clear_start = 1'b0, draw_we = 1'b0, draw_data = 1'b0;
  logic          swap_req = 1'b0, frame_start = 1'b0;
  logic [CW-1:0] DrawX = '0, DrawY = '0, ReadX = '0, ReadY = '0;

  logic cdone_o [2], sdone_o [2], ready_o [2], rd_o [2], front_o [2], busy_o [2];

  always #5 Clk = ~Clk;

  frame_buffer_ctrl #(.H_RES(H), .V_RES(V), .COORD_W(CW), .PIX_W(1), .NUM_BUF(2), .CLEAR_VAL(1'b0)) u_dbl (
    .Clk(Clk), .Reset_n(Reset_n), .clear_start(clear_start), .clear_done(cdone_o[0]),
    .draw_we(draw_we), .DrawX(DrawX), .DrawY(DrawY), .draw_data(draw_data), .draw_ready(ready_o[0]),
    .ReadX(ReadX), .ReadY(ReadY), .read_data(rd_o[0]), .swap_req(swap_req), .frame_start(frame_start),
    .swap_done(sdone_o[0]), .front_sel(front_o[0]), .busy(busy_o[0]));

  frame_buffer_ctrl #(.H_RES(H), .V_RES(V), .COORD_W(CW), .PIX_W(1), .NUM_BUF(1), .CLEAR_VAL(1'b0)) u_sgl (
    .Clk(Clk), .Reset_n(Reset_n), .clear_start(clear_start), .clear_done(cdone_o[1]),
    .draw_we(draw_we), .DrawX(DrawX), .DrawY(DrawY), .draw_data(draw_data), .draw_ready(ready_o[1]),
    .ReadX(ReadX), .ReadY(ReadY), .read_data(rd_o[1]), .swap_req(swap_req), .frame_start(frame_start),
    .swap_done(sdone_o[1]), .front_sel(front_o[1]), .busy(busy_o[1]));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pixel arrays per instance, clearing expressed as pixels still to clear.
  bit m_mem   [2][2*FRAME];
  bit m_known [2][2*FRAME];
  bit m_front [2] = '{1'b0, 1'b0};
  bit e_rd    [2] = '{1'b0, 1'b0};
  bit e_known [2] = '{1'b1, 1'b1};
  int clear_left = 0;
  bit waiting = 1'b0, pend = 1'b0, e_cdone = 1'b0, e_sdone = 1'b0;

  task automatic model_reset();
    clear_left = 0;
    waiting    = 1'b0;
    pend       = 1'b0;
    e_cdone    = 1'b0;
    e_sdone    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_front[k] = 1'b0;
      e_rd[k]    = 1'b0;
      e_known[k] = 1'b1;
    end
  endtask

  task automatic model_step();
    bit rd_in, dr_in;
    int ridx, didx, bk, a;
    rd_in = (int'(ReadX) < H) && (int'(ReadY) < V);
    dr_in = (int'(DrawX) < H) && (int'(DrawY) < V);
    ridx  = int'(ReadY) * H + int'(ReadX);
    didx  = int'(DrawY) * H + int'(DrawX);
    e_cdone = 1'b0;
    e_sdone = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bk = (k == 0) ? int'(!m_front[k]) : 0;
      if (rd_in) begin
        a          = int'(m_front[k]) * FRAME + ridx;
        e_rd[k]    = m_mem[k][a];
        e_known[k] = m_known[k][a];
      end else begin
        e_rd[k]    = 1'b0;
        e_known[k] = 1'b1;
      end
      if (clear_left > 0) begin
        a = bk * FRAME + (FRAME - clear_left);
        m_mem[k][a]   = 1'b0;
        m_known[k][a] = 1'b1;
      end else if (!waiting && draw_we && dr_in) begin
        a = bk * FRAME + didx;
        m_mem[k][a]   = draw_data;
        m_known[k][a] = 1'b1;
      end
    end
    if (clear_left > 0) begin
      if (swap_req) pend = 1'b1;
      clear_left--;
      if (clear_left == 0) e_cdone = 1'b1;
    end else if (waiting) begin
      if (frame_start) begin
        m_front[0] = !m_front[0];
        e_sdone    = 1'b1;
        pend       = 1'b0;
        waiting    = 1'b0;
      end
    end else begin
      if (clear_start) clear_left = FRAME;
      else if (swap_req || pend) waiting = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge Clk or negedge Reset_n);
    if (!Reset_n) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge Clk);
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("busy[%0d]", k), busy_o[k], (clear_left > 0) || waiting);
        check($sformatf("draw_ready[%0d]", k), ready_o[k], !((clear_left > 0) || waiting));
        check($sformatf("clear_done[%0d]", k), cdone_o[k], e_cdone);
        check($sformatf("swap_done[%0d]", k), sdone_o[k], e_sdone);
        check($sformatf("front_sel[%0d]", k), front_o[k], m_front[k]);
        if (e_known[k]) check($sformatf("read_data[%0d]", k), rd_o[k], e_rd[k]);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic set_read(input int x, input int y);
    ReadX = CW'(x);
    ReadY = CW'(y);
  endtask

  task automatic draw(input int x, input int y, input bit d);
    draw_we   = 1'b1;
    DrawX     = CW'(x);
    DrawY     = CW'(y);
    draw_data = d;
  endtask

  task automatic swap_now();
    swap_req = 1'b1;
    step();
    swap_req    = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic run_clear(output int busy_cnt, output int pulses);
    busy_cnt = 0;
    pulses   = 0;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy_o[0]) busy_cnt++;
      if (cdone_o[0]) pulses++;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, pc;
    bit seen;

    repeat (3) step();
    Reset_n = 1'b1;
    chk_en  = 1'b1;
    check("rst_busy", busy_o[0], 0);
    check("rst_draw_ready", ready_o[0], 1);
    check("rst_front_sel", front_o[0], 0);
    check("rst_read_data", rd_o[0], 0);
    check("rst_clear_done", cdone_o[0], 0);

    // 1: clear back, swap, clear the other buffer, then everything reads 0
    run_clear(bc, pc);
    check("t1_busy_cycles", bc, 32);
    check("t1_clear_done_pulses", pc, 1);
    swap_now();
    check("t1_front_after_swap", front_o[0], 1);
    check("t1_front_single", front_o[1], 0);
    run_clear(bc, pc);
    check("t1_busy_cycles2", bc, 32);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        set_read(x, y);
        step();
        check($sformatf("t1_read_%0d_%0d", x, y), rd_o[0], 0);
      end

    // 2: draw into back is invisible until swap; single buffer sees it next cycle
    draw(3, 2, 1'b1);
    set_read(3, 2);
    step();
    draw_we = 1'b0;
    check("t2_read_same_cycle_single", rd_o[1], 0);
    step();
    check("t2_read_front_old", rd_o[0], 0);
    check("t2_read_single_new", rd_o[1], 1);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    check("t2_wait_busy", busy_o[0], 1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("t2_swap_done", sdone_o[0], 1);
    check("t2_front_sel", front_o[0], 0);
    check("t2_swap_done_single", sdone_o[1], 1);
    check("t2_front_single", front_o[1], 0);
    step();
    check("t2_read_after_swap", rd_o[0], 1);
    check("t2_swap_done_once", sdone_o[0], 0);

    // 3: out-of-range draws are dropped and out-of-range reads return CLEAR_VAL
    draw(8, 0, 1'b1);
    step();
    draw(0, 4, 1'b1);
    step();
    draw_we = 1'b0;
    set_read(8, 0);
    step();
    check("t3_read_x_oob", rd_o[0], 0);
    set_read(0, 4);
    step();
    check("t3_read_y_oob", rd_o[0], 0);
    set_read(0, 0);
    step();
    check("t3_alias_00", rd_o[0], 0);
    check("t3_alias_00_single", rd_o[1], 0);
    set_read(0, 1);
    step();
    check("t3_alias_01_single", rd_o[1], 0);
    swap_now();
    check("t3_front_sel", front_o[0], 1);
    step();
    check("t3_alias_01", rd_o[0], 0);

    // 4: swap_req during CLEAR is held and served after the clear
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (4) step();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (cdone_o[0]) seen = 1'b1;
    end
    check("t4_clear_done_seen", seen, 1);
    step();
    check("t4_swap_wait_busy", busy_o[0], 1);
    repeat (3) step();
    check("t4_front_held", front_o[0], 1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("t4_swap_done", sdone_o[0], 1);
    check("t4_front_toggled", front_o[0], 0);
    check("t4_idle", busy_o[0], 0);

    // 5: reset in the middle of CLEAR
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (9) step();
    Reset_n = 1'b0;
    #1;
    check("t5_busy", busy_o[0], 0);
    check("t5_draw_ready", ready_o[0], 1);
    check("t5_front_sel", front_o[0], 0);
    step();
    Reset_n = 1'b1;
    pc = 0;
    for (int i = 0; i < 40; i++) begin
      if (cdone_o[0]) pc++;
      step();
    end
    check("t5_no_clear_done", pc, 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      draw_we     = 1'($urandom_range(0, 1));
      DrawX       = CW'($urandom_range(0, 9));
      DrawY       = CW'($urandom_range(0, 5));
      draw_data   = 1'($urandom_range(0, 1));
      ReadX       = CW'($urandom_range(0, 9));
      ReadY       = CW'($urandom_range(0, 5));
      clear_start = ($urandom_range(0, 149) == 0);
      swap_req    = ($urandom_range(0, 24) == 0);
      frame_start = ($urandom_range(0, 15) == 0);
      Reset_n     = ($urandom_range(0, 1999) != 0);
      step();
    end
    Reset_n     = 1'b1;
    clear_start = 1'b0;
    swap_req    = 1'b0;
    frame_start = 1'b0;
    draw_we     = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
